cmm_row_streamer: RTL
=====================

Name: cmm_row_streamer

Overview:
- Parametrised row-output collector for the consecutive matrix multiplier.
- Captures each finished result row (DONE_ROW, ROW_NUM, OUT) into a small row FIFO.
- Streams the row out one element per handshake on a valid/ready interface, tagged with row, index and last flags.
- Replaces ad-hoc row slicing in benches and feeds downstream writers or DMA; generalises the fixed 8x32-bit row to any element width and count, and adds buffering, back-pressure, overflow and end-of-matrix signalling.

Parameters:
ELEM_W, 32, bits per matrix element
NUM_ELEM, 8, elements per result row (OUT width = ELEM_W*NUM_ELEM)
ROW_W, 5, width of ROW_NUM
DEPTH, 4, row FIFO depth in whole rows (power of 2, >=2)

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
CLR  in  1  synchronous clear (tie to multiplier START); empties FIFO, clears flags
DONE_ROW  in  1  row-complete strobe from multiplier (pulse or level; rising edge used)
ROW_NUM  in  ROW_W  index of row on OUT
OUT  in  ELEM_W*NUM_ELEM  result row; element k = OUT[ELEM_W*k +: ELEM_W]
DONE  in  1  matrix-complete from multiplier (rising edge used)
M_VALID  out  1  element available
M_READY  in  1  downstream accepts element
M_DATA  out  ELEM_W  current element
M_IDX  out  $clog2(NUM_ELEM)  element index within row
M_ROW  out  ROW_W  row number of current element
M_LAST  out  1  M_IDX == NUM_ELEM-1
M_EOM  out  1  last element of last buffered row after DONE seen
OVERFLOW  out  1  sticky: a row arrived while FIFO full
ALL_DONE  out  1  one-cycle pulse: DONE seen and all rows drained

Behaviour:
- Reset (RSTN low, async): FIFO empty, pointers/count/element index 0, edge registers 0, M_VALID 0, M_DATA 0, M_IDX 0, M_ROW 0, M_LAST 0, M_EOM 0, OVERFLOW 0, ALL_DONE 0.
- Mid-operation reset discards everything; no partial row survives.
- Edge detect: push_req = DONE_ROW & ~done_row_q, where done_row_q is DONE_ROW registered. DONE is handled the same way.
- Push: on push_req at edge t, OUT and ROW_NUM are stored in the tail slot. M_VALID rises in the cycle after t if the FIFO was empty (1-cycle latency).
- Full: push is accepted if count<DEPTH, or if the head row's last element is handshaken in the same cycle (simultaneous pop frees the slot). Otherwise the row is dropped and OVERFLOW is set (sticky until CLR or reset).
- Output: M_VALID = (count!=0). M_DATA/M_ROW come from the head slot, element selected by idx. Outputs stay stable while M_VALID & ~M_READY.
- Handshake: M_VALID & M_READY advances idx. At idx==NUM_ELEM-1 idx wraps to 0 and the head row pops. Back-to-back accepts give one element per cycle.
- Push on an empty FIFO while ~M_VALID: no same-cycle bypass. Data appears next cycle.
- DONE: sets done_seen. M_EOM = M_LAST & done_seen & (count==1) & no push_req this cycle.
- ALL_DONE: pulses one cycle when done_seen & count==0, then clears done_seen. If DONE rises with the FIFO already empty, ALL_DONE pulses the next cycle.
- CLR: synchronous, takes priority over push/pop that cycle. Empties FIFO, idx=0, clears done_seen, OVERFLOW, ALL_DONE. Edge registers still update.
- State: head/tail pointers (log2 DEPTH), count (0..DEPTH), idx, done_seen. No implicit state beyond these.

Optional Feature:
- Macro CMM_ROW_SEQ_CHECK_EN.
- When defined: adds output SEQ_ERR (1 bit, sticky, reset 0, cleared by CLR). Set when an accepted row's ROW_NUM != previous accepted ROW_NUM + 1 (mod 2^ROW_W). The first row after reset/CLR must be 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cmm_pkg: default ELEM_W/NUM_ELEM/ROW_W constants, IDX_W = $clog2(NUM_ELEM), and a row-slot typedef struct {row data, row number}.
- One sub-module, cmm_row_fifo: DEPTH-entry row FIFO with push/pop/full/empty/count. The streamer holds edge detect, element mux, idx counter and done/flag logic.

Test Plan:
- Single row: defaults, OUT = elements 0x11..0x88 (k=0 is 0x11), ROW_NUM=0, M_READY=1 -> M_VALID next cycle, 8 beats 0x11..0x88, M_IDX 0..7, M_LAST on beat 7, M_ROW=0.
- Back-pressure: M_READY toggles 1,0,0,1,... -> no element duplicated or skipped; M_DATA stable while stalled.
- Overflow: M_READY=0, 5 DONE_ROW pulses rows 0..4 -> rows 0..3 buffered, OVERFLOW=1 after 5th, row 4 never appears. Then M_READY=1 -> 32 beats rows 0..3.
- Full with simultaneous pop: FIFO full, push_req in the same cycle as row-0 beat 7 handshake -> row accepted, OVERFLOW stays 0.
- End of matrix: 32 rows streamed, DONE after row 31 -> M_EOM only on row 31 beat 7, ALL_DONE one-cycle pulse the next cycle. DONE with empty FIFO -> ALL_DONE next cycle.
- Reset/CLR mid-row: assert RSTN=0 (then separately CLR=1) at row 2 beat 3 -> all outputs return to reset values; next row streams from idx 0. With CMM_ROW_SEQ_CHECK_EN, rows 0,1,3 -> SEQ_ERR=1 after row 3.

Source files
------------

// File: rtl/cmm_pkg.sv
// rtl/cmm_pkg.sv - default geometry and row-slot type for the matrix row streamer
package cmm_pkg;

    localparam int CMM_ELEM_W   = 32;
    localparam int CMM_NUM_ELEM = 8;
    localparam int CMM_ROW_W    = 5;
    localparam int CMM_DEPTH    = 4;
    localparam int IDX_W        = $clog2(CMM_NUM_ELEM);

    typedef struct packed {
        logic [CMM_ELEM_W*CMM_NUM_ELEM-1:0] data;
        logic [CMM_ROW_W-1:0]               row;
    } row_slot_t;

endpackage

// File: rtl/cmm_row_fifo.sv
// rtl/cmm_row_fifo.sv - DEPTH-entry whole-row FIFO; caller guarantees no push when full without a pop
module cmm_row_fifo #(
    parameter int W     = 261,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_wdata,
    output logic [W-1:0]                 o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PTR_W'(1);
            if (i_pop)  r_head <= r_head + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Row storage carries no reset; consumers only look at it while count != 0.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_tail] <= i_wdata;
    end

    assign o_rdata = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/cmm_row_streamer.sv
// rtl/cmm_row_streamer.sv - buffers multiplier result rows and streams them per element; CMM_ROW_SEQ_CHECK_EN adds SEQ_ERR
module cmm_row_streamer
    import cmm_pkg::*;
#(
    parameter int ELEM_W   = CMM_ELEM_W,
    parameter int NUM_ELEM = CMM_NUM_ELEM,
    parameter int ROW_W    = CMM_ROW_W,
    parameter int DEPTH    = CMM_DEPTH
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          CLR,
    input  logic                          DONE_ROW,
    input  logic [ROW_W-1:0]              ROW_NUM,
    input  logic [ELEM_W*NUM_ELEM-1:0]    OUT,
    input  logic                          DONE,
    output logic                          M_VALID,
    input  logic                          M_READY,
    output logic [ELEM_W-1:0]             M_DATA,
    output logic [$clog2(NUM_ELEM)-1:0]   M_IDX,
    output logic [ROW_W-1:0]              M_ROW,
    output logic                          M_LAST,
    output logic                          M_EOM,
    output logic                          OVERFLOW,
    output logic                          ALL_DONE
`ifdef CMM_ROW_SEQ_CHECK_EN
    ,
    output logic                          SEQ_ERR
`endif
);

    localparam int DATA_W = ELEM_W*NUM_ELEM;
    localparam int SLOT_W = DATA_W + ROW_W;
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int LIDX_W = $clog2(NUM_ELEM);

    logic              r_done_row_q;
    logic              r_done_q;
    logic              r_done_seen;
    logic              r_overflow;
    logic [LIDX_W-1:0] r_idx;

    logic              w_push_req;
    logic              w_done_req;
    logic              w_valid;
    logic              w_hs;
    logic              w_last;
    logic              w_pop;
    logic              w_push_acc;
    logic              w_full;
    logic              w_empty;
    logic              w_all_done;
    logic [CNT_W-1:0]  w_count;
    logic [SLOT_W-1:0] w_head;
    logic [ELEM_W-1:0] w_elems [NUM_ELEM];

    assign w_push_req = DONE_ROW & ~r_done_row_q;
    assign w_done_req = DONE & ~r_done_q;
    assign w_valid    = ~w_empty;
    assign w_hs       = w_valid & M_READY;
    assign w_last     = w_valid & (r_idx == LIDX_W'(NUM_ELEM-1));
    assign w_pop      = w_hs & w_last;
    // A full FIFO still takes the row when the head row leaves in the same cycle.
    assign w_push_acc = w_push_req & (~w_full | w_pop);
    assign w_all_done = r_done_seen & w_empty;

    cmm_row_fifo #(
        .W     (SLOT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_clr   (CLR),
        .i_push  (w_push_acc & ~CLR),
        .i_pop   (w_pop & ~CLR),
        .i_wdata ({OUT, ROW_NUM}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
        assign w_elems[k] = w_head[ROW_W + ELEM_W*k +: ELEM_W];
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_done_row_q <= 1'b0;
            r_done_q     <= 1'b0;
            r_done_seen  <= 1'b0;
            r_overflow   <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_done_row_q <= DONE_ROW;
            r_done_q     <= DONE;
            if (CLR) begin
                r_done_seen <= 1'b0;
                r_overflow  <= 1'b0;
                r_idx       <= '0;
            end else begin
                if (w_hs) r_idx <= w_last ? '0 : r_idx + LIDX_W'(1);
                if (w_push_req && !w_push_acc) r_overflow <= 1'b1;
                if (w_done_req)      r_done_seen <= 1'b1;
                else if (w_all_done) r_done_seen <= 1'b0;
            end
        end
    end

    // Head data is masked while empty so the idle bus reads as zero.
    assign M_VALID  = w_valid;
    assign M_DATA   = w_valid ? w_elems[r_idx] : '0;
    assign M_ROW    = w_valid ? w_head[ROW_W-1:0] : '0;
    assign M_IDX    = r_idx;
    assign M_LAST   = w_last;
    assign M_EOM    = w_last & r_done_seen & (w_count == CNT_W'(1)) & ~w_push_req;
    assign OVERFLOW = r_overflow;
    assign ALL_DONE = w_all_done;

`ifdef CMM_ROW_SEQ_CHECK_EN
    logic [ROW_W-1:0] r_prev_row;
    logic             r_seq_first;
    logic             r_seq_err;
    logic [ROW_W-1:0] w_exp_row;

    assign w_exp_row = r_seq_first ? '0 : r_prev_row + ROW_W'(1);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_prev_row  <= '0;
            r_seq_first <= 1'b1;
            r_seq_err   <= 1'b0;
        end else if (CLR) begin
            r_prev_row  <= '0;
            r_seq_first <= 1'b1;
            r_seq_err   <= 1'b0;
        end else if (w_push_acc) begin
            if (ROW_NUM != w_exp_row) r_seq_err <= 1'b1;
            r_prev_row  <= ROW_NUM;
            r_seq_first <= 1'b0;
        end
    end

    assign SEQ_ERR = r_seq_err;
`endif

endmodule
